ha_bist_checker: RTL and testbench

HA_BIST_CHECKER -- requirements
Module: ha_bist_checker

---
 rtl/ha_bist_checker.sv | 140 ++++++++++++++
 tb/tb_ha_bist_checker.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ha_bist_checker.sv
`default_nettype none
// ============================================================================
//  Module      : ha_bist_checker
//  Description : Built-in self-test sequencer for an external half adder or
//                half subtractor. Walks the four operand vectors 00,01,10,11,
//                lets each settle for SETTLE_CYC cycles, compares the DUT
//                result against a golden model and reports per-vector
//                mismatches, a saturating error count and a pass flag.
//  Ports       :
//     clk       in   1  clock, rising edge
//     rst_n     in   1  synchronous active-low reset
//     start     in   1  run request, honoured only in IDLE
//     mode      in   1  golden model: 0 = half adder, 1 = half subtractor
//     dut_a     out  1  registered operand a to the DUT
//     dut_b     out  1  registered operand b to the DUT
//     dut_s     in   1  DUT sum / difference
//     dut_c     in   1  DUT carry / borrow
//     busy      out  1  run in progress
//     done      out  1  one-cycle end-of-run pulse
//     pass      out  1  last completed run had no mismatches
//     err_cnt   out  3  mismatching vectors in current / last run (0..4)
//     fail_vec  out  4  bit i set when vector i mismatched
//     vec_idx   out  2  index of the vector currently applied
//  Revision    : 1.0  initial release
// ============================================================================
module ha_bist_checker #(
   parameter int unsigned SETTLE_CYC = 10
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       mode,
   output logic       dut_a,
   output logic       dut_b,
   input  logic       dut_s,
   input  logic       dut_c,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [2:0] err_cnt,
   output logic [3:0] fail_vec,
   output logic [1:0] vec_idx
);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_APPLY  = 3'd1,
      ST_SETTLE = 3'd2,
      ST_SAMPLE = 3'd3,
      ST_DONE   = 3'd4
   } state_t;

   localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYC - 1);

   state_t     state;
   logic       mode_q;
   logic [7:0] settle_cnt;

   // Golden result for the operands currently driven onto the DUT.
   logic gold_s;
   logic gold_c;
   logic mismatch;

   assign gold_s   = dut_a ^ dut_b;
   assign gold_c   = mode_q ? (~dut_a & dut_b) : (dut_a & dut_b);
   assign mismatch = (dut_s != gold_s) || (dut_c != gold_c);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         mode_q     <= 1'b0;
         settle_cnt <= 8'd0;
         dut_a      <= 1'b0;
         dut_b      <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         pass       <= 1'b0;
         err_cnt    <= 3'd0;
         fail_vec   <= 4'd0;
         vec_idx    <= 2'd0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  mode_q   <= mode;
                  err_cnt  <= 3'd0;
                  fail_vec <= 4'd0;
                  pass     <= 1'b0;
                  vec_idx  <= 2'd0;
                  busy     <= 1'b1;
                  state    <= ST_APPLY;
               end
            end
            ST_APPLY: begin
               dut_a      <= vec_idx[1];
               dut_b      <= vec_idx[0];
               settle_cnt <= 8'd0;
               state      <= ST_SETTLE;
            end
            ST_SETTLE: begin
               // Counter runs 0..SETTLE_CYC-1, giving exactly SETTLE_CYC cycles here.
               if (settle_cnt == SETTLE_LAST) begin
                  state <= ST_SAMPLE;
               end else begin
                  settle_cnt <= settle_cnt + 8'd1;
               end
            end
            ST_SAMPLE: begin
               if (mismatch) begin
                  if (err_cnt != 3'd4) begin
                     err_cnt <= err_cnt + 3'd1;
                  end
                  fail_vec[vec_idx] <= 1'b1;
               end
               if (vec_idx == 2'd3) begin
                  state <= ST_DONE;
               end else begin
                  vec_idx <= vec_idx + 2'd1;
                  state   <= ST_APPLY;
               end
            end
            ST_DONE: begin
               done  <= 1'b1;
               pass  <= (err_cnt == 3'd0);
               busy  <= 1'b0;
               // Operands return to 0 together with busy.
               dut_a <= 1'b0;
               dut_b <= 1'b0;
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_ha_bist_checker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ha_bist_checker
//  Description : Self-checking bench for ha_bist_checker. A configurable
//                external DUT model (correct HA/HS, stuck sum, random
//                per-vector flips, optional 10-cycle output delay) is driven
//                by the checker; results are compared with expectations
//                computed from the vector rules.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ha_bist_checker;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic       mode;
   logic       dut_a, dut_b;
   logic       dut_s, dut_c;
   logic       busy, done, pass;
   logic [2:0] err_cnt;
   logic [3:0] fail_vec;
   logic [1:0] vec_idx;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   ha_bist_checker #(.SETTLE_CYC(10)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
      .dut_a(dut_a), .dut_b(dut_b), .dut_s(dut_s), .dut_c(dut_c),
      .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
      .fail_vec(fail_vec), .vec_idx(vec_idx)
   );

   // External DUT model: 0 = half adder, 1 = half subtractor, 2 = HA with sum stuck at 0.
   int         kind;
   logic [3:0] mask_s;
   logic [3:0] mask_c;
   bit         use_dly;
   logic [19:0] dly;
   logic [1:0]  ab;

   always_ff @(posedge clk) dly <= {dly[17:0], dut_a, dut_b};

   always_comb begin
      ab    = use_dly ? dly[19:18] : {dut_a, dut_b};
      dut_s = ab[1] ^ ab[0];
      dut_c = (kind == 1) ? (~ab[1] & ab[0]) : (ab[1] & ab[0]);
      if (kind == 2) dut_s = 1'b0;
      dut_s = dut_s ^ mask_s[ab];
      dut_c = dut_c ^ mask_c[ab];
   end

   // Expected per-vector failure set from arithmetic definitions of the models.
   function automatic logic [3:0] ref_fail(input bit m, input int k,
                                           input logic [3:0] ms, input logic [3:0] mc);
      logic [3:0] r;
      r = 4'd0;
      for (int i = 0; i < 4; i++) begin
         int a, b, gs, gc, xs, xc;
         a  = i / 2;
         b  = i % 2;
         gs = (a + b) % 2;
         gc = m ? int'(b > a) : (a + b) / 2;
         xs = (k == 2) ? 0 : (a + b) % 2;
         xc = (k == 1) ? int'(b > a) : (a + b) / 2;
         xs = xs ^ int'(ms[i]);
         xc = xc ^ int'(mc[i]);
         r[i] = (gs != xs) || (gc != xc);
      end
      return r;
   endfunction

   // Starts a run and observes 60 edges after the accepting edge.
   task automatic run(input bit repulse, output int done_at, output int pulses,
                      output int trace_bad);
      done_at = -1; pulses = 0; trace_bad = 0;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int n = 1; n <= 60; n++) begin
         if (repulse && (n == 5 || n == 30)) start = 1'b1;
         @(posedge clk); #1;
         start = 1'b0;
         if (done) begin
            pulses++;
            if (done_at < 0) done_at = n;
         end
         if (n <= 49) begin
            int       k;
            logic [1:0] e_ab, e_vi;
            logic       e_busy;
            k      = (n <= 48) ? (n - 1) / 12 : 0;
            e_ab   = 2'(k);
            e_vi   = 2'((n / 12 > 3) ? 3 : n / 12);
            e_busy = (n <= 48);
            if ({dut_a, dut_b} !== e_ab || vec_idx !== e_vi || busy !== e_busy)
               trace_bad++;
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; mode = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_tests++;
      if ({busy, done, pass, err_cnt, fail_vec, vec_idx, dut_a, dut_b} !== 15'd0) begin
         n_fail++;
         $display("FAIL reset_state: got %b want 0", {busy, done, pass, err_cnt, fail_vec, vec_idx, dut_a, dut_b});
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_model(input string name, input bit m, input int k,
                             input logic [3:0] ms, input logic [3:0] mc, input bit dl);
      int d_at, pl, tb_bad;
      logic [3:0] ef;
      kind = k; mask_s = ms; mask_c = mc; use_dly = dl; mode = m;
      ef = ref_fail(m, k, ms, mc);
      run(1'b0, d_at, pl, tb_bad);
      n_tests++;
      if (d_at != 49 || pl != 1) begin
         n_fail++;
         $display("FAIL %s done_timing: done_at=%0d pulses=%0d want 49/1", name, d_at, pl);
      end
      n_tests++;
      if (fail_vec !== ef || err_cnt !== 3'($countones(ef)) || pass !== (ef == 4'd0)) begin
         n_fail++;
         $display("FAIL %s result: fail_vec=%b err_cnt=%0d pass=%b want %b/%0d/%b",
                  name, fail_vec, err_cnt, pass, ef, $countones(ef), ef == 4'd0);
      end
   endtask

   task automatic test_trace();
      int d_at, pl, tb_bad;
      kind = 0; mask_s = 0; mask_c = 0; use_dly = 0; mode = 0;
      run(1'b0, d_at, pl, tb_bad);
      n_tests++;
      if (tb_bad != 0) begin
         n_fail++;
         $display("FAIL operand_trace: bad_cycles=%0d want 0", tb_bad);
      end
   endtask

   task automatic test_restart_ignored();
      int d_at, pl, tb_bad;
      kind = 2; mask_s = 0; mask_c = 0; use_dly = 0; mode = 0;
      run(1'b1, d_at, pl, tb_bad);
      n_tests++;
      if (d_at != 49 || pl != 1 || tb_bad != 0) begin
         n_fail++;
         $display("FAIL restart_ignored: done_at=%0d pulses=%0d trace_bad=%0d want 49/1/0", d_at, pl, tb_bad);
      end
      n_tests++;
      if (fail_vec !== 4'b0110 || err_cnt !== 3'd2 || pass !== 1'b0) begin
         n_fail++;
         $display("FAIL restart_result: fail_vec=%b err_cnt=%0d pass=%b want 0110/2/0", fail_vec, err_cnt, pass);
      end
   endtask

   task automatic test_reset_abort();
      int d_at, pl, tb_bad, pulses;
      kind = 0; mask_s = 0; mask_c = 0; use_dly = 0; mode = 0;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      n_tests++;
      if ({busy, done, pass, err_cnt, fail_vec, vec_idx, dut_a, dut_b} !== 15'd0) begin
         n_fail++;
         $display("FAIL abort_state: got %b want 0", {busy, done, pass, err_cnt, fail_vec, vec_idx, dut_a, dut_b});
      end
      pulses = 0;
      for (int n = 0; n < 60; n++) begin
         @(posedge clk); #1;
         if (done) pulses++;
      end
      n_tests++;
      if (pulses != 0) begin
         n_fail++;
         $display("FAIL abort_no_done: pulses=%0d want 0", pulses);
      end
      run(1'b0, d_at, pl, tb_bad);
      n_tests++;
      if (d_at != 49 || pl != 1 || pass !== 1'b1 || tb_bad != 0) begin
         n_fail++;
         $display("FAIL abort_rerun: done_at=%0d pulses=%0d pass=%b trace_bad=%0d want 49/1/1/0", d_at, pl, pass, tb_bad);
      end
   endtask

   task automatic test_back_to_back();
      int first, second, pulses;
      kind = 1; mask_s = 0; mask_c = 0; use_dly = 0; mode = 1;
      first = -1; second = -1; pulses = 0;
      start = 1'b1;
      @(posedge clk); #1;
      for (int n = 1; n <= 110; n++) begin
         @(posedge clk); #1;
         if (done) begin
            pulses++;
            if (first < 0) first = n;
            else if (second < 0) second = n;
         end
         if (n == 60) mode = 1'b0;   // must not affect the run already in progress
      end
      start = 1'b0;
      repeat (60) @(posedge clk);
      #1;
      n_tests++;
      if (first != 49 || second != 99 || pulses != 2) begin
         n_fail++;
         $display("FAIL back_to_back: done at %0d,%0d pulses=%0d want 49,99,2", first, second, pulses);
      end
      // Third run (accepted at edge 100) saw mode=0 with an HS model.
      n_tests++;
      if (fail_vec !== 4'b1010 || err_cnt !== 3'd2 || pass !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL back_to_back_result: fail_vec=%b err_cnt=%0d pass=%b busy=%b want 1010/2/0/0", fail_vec, err_cnt, pass, busy);
      end
   endtask

   task automatic test_random();
      for (int it = 0; it < 8; it++) begin
         test_model("random", 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)),
                    4'($urandom), 4'($urandom), 1'b0);
      end
   endtask

   initial begin
      kind = 0; mask_s = 0; mask_c = 0; use_dly = 0;
      start = 0; mode = 0; rst_n = 0;
      test_reset();
      test_model("ha_correct",   1'b0, 0, 4'd0, 4'd0, 1'b0);
      test_model("hs_correct",   1'b1, 1, 4'd0, 4'd0, 1'b0);
      test_model("hs_as_ha",     1'b0, 1, 4'd0, 4'd0, 1'b0);
      test_model("ha_stuck_s",   1'b0, 2, 4'd0, 4'd0, 1'b0);
      test_model("ha_recover",   1'b0, 0, 4'd0, 4'd0, 1'b0);
      test_model("all_fail_sat", 1'b0, 0, 4'hF, 4'hF, 1'b0);
      test_model("slow_model",   1'b1, 1, 4'd0, 4'd0, 1'b1);
      test_trace();
      test_restart_ignored();
      test_reset_abort();
      test_back_to_back();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
